// File: rtl/dmem_mmio_responder_if.sv
// Data-memory port between the core (master) and the responder (slave).
// Write-side signals are sampled on the rising clock edge. The read data is
// combinational from the address.
interface dmem_mmio_responder_if;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;

    modport master (output addr, output wd, output we, input rd);
    modport slave  (input addr, input wd, input we, output rd);
endinterface

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: the slave end of the core's data-memory port.
// Each access is decoded to one of three targets: word RAM, an 8-word MMIO
// block (GPIO plus a down-counting timer), or unmapped space.
// Reads are zero-latency. Writes commit on the rising edge.
// Optional feature macro: DMEM_TIMER_EN. When it is defined, the timer
// registers, the timer FSM and irq are built. When it is undefined, the
// timer offsets read 0, STAT.expired reads 0 and irq is tied low.
module dmem_mmio_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0800
) (
    input  logic                          clk,
    input  logic                          rst,
    dmem_mmio_responder_if.slave          bus,
    input  logic [31:0]                   gpio_in,
    output logic [31:0]                   gpio_out,
    output logic                          irq
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    localparam logic [2:0] OFF_GPIO_IN  = 3'd0;
    localparam logic [2:0] OFF_GPIO_OUT = 3'd1;
    localparam logic [2:0] OFF_CTRL     = 3'd2;
    localparam logic [2:0] OFF_LOAD     = 3'd3;
    localparam logic [2:0] OFF_COUNT    = 3'd4;
    localparam logic [2:0] OFF_STAT     = 3'd5;

    // Address decode. addr[1:0] is ignored because all accesses are whole words.
    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [2:0]    off;
    logic          mmio_wr;
    logic          bad_wr;

    assign ram_hit  = (bus.addr < RAM_BYTES);
    assign mmio_hit = (bus.addr[31:5] == MMIO_BASE[31:5]);
    assign ram_idx  = bus.addr[AW+1:2];
    assign off      = bus.addr[4:2];
    assign mmio_wr  = bus.we && mmio_hit;
    assign bad_wr   = bus.we && !ram_hit && !mmio_hit;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] gpio_meta_q, gpio_sync_q;
    logic [31:0] gpio_out_q, gpio_out_d;
    logic        bus_err_q, bus_err_d;

`ifdef DMEM_TIMER_EN
    typedef enum logic {IDLE, RUN} tmr_state_e;

    tmr_state_e  state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;      // {ie, auto, en}
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic        set_exp;

    // Timer FSM next state. Hardware actions are computed first, so that a
    // software write to the same register in this cycle overrides them.
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        set_exp = 1'b0;
        case (state_q)
            RUN: begin
                if (count_q != 32'd0) begin
                    count_d = count_q - 32'd1;
                end else begin
                    set_exp = 1'b1;
                    if (ctrl_q[1]) count_d = load_q;
                    else           ctrl_d[0] = 1'b0;
                end
            end
            default: ;
        endcase
        if (mmio_wr && off == OFF_CTRL) ctrl_d = bus.wd[2:0];
        if (mmio_wr && off == OFF_LOAD) begin
            load_d  = bus.wd;
            count_d = bus.wd;
        end
        state_d = ctrl_d[0] ? RUN : IDLE;
    end

    // Expired flag. Write-1-to-clear is applied first and the hardware set
    // is applied after it, so a set in the same cycle wins over a clear.
    always_comb begin
        expired_d = expired_q;
        if (mmio_wr && off == OFF_STAT && bus.wd[0]) expired_d = 1'b0;
        if (set_exp) expired_d = 1'b1;
    end

    // Timer state register. Reset is asynchronous, so irq drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign irq = expired_q & ctrl_q[2];
`else
    assign irq = 1'b0;
`endif

    // Next state for GPIO_OUT and for the bus-error flag. The bus-error set
    // wins over a W1C clear in the same cycle.
    always_comb begin
        gpio_out_d = gpio_out_q;
        bus_err_d  = bus_err_q;
        if (mmio_wr && off == OFF_GPIO_OUT) gpio_out_d = bus.wd;
        if (mmio_wr && off == OFF_STAT && bus.wd[1]) bus_err_d = 1'b0;
        if (bad_wr) bus_err_d = 1'b1;
    end

    // GPIO registers, the two-flop input synchronizer and the bus-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_meta_q <= '0;
            gpio_sync_q <= '0;
            gpio_out_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            gpio_meta_q <= gpio_in;
            gpio_sync_q <= gpio_meta_q;
            gpio_out_q  <= gpio_out_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Word RAM. It has no reset, so its contents survive rst.
    always_ff @(posedge clk) begin
        if (bus.we && ram_hit) mem_q[ram_idx] <= bus.wd;
    end

    // Zero-latency read mux. Unmapped space and unused offsets return 0.
    always_comb begin
        bus.rd = 32'h0;
        if (ram_hit) begin
            bus.rd = mem_q[ram_idx];
        end else if (mmio_hit) begin
            case (off)
                OFF_GPIO_IN:  bus.rd = gpio_sync_q;
                OFF_GPIO_OUT: bus.rd = gpio_out_q;
`ifdef DMEM_TIMER_EN
                OFF_CTRL:     bus.rd = {29'd0, ctrl_q};
                OFF_LOAD:     bus.rd = load_q;
                OFF_COUNT:    bus.rd = count_q;
                OFF_STAT:     bus.rd = {30'd0, bus_err_q, expired_q};
`else
                OFF_STAT:     bus.rd = {30'd0, bus_err_q, 1'b0};
`endif
                default:      bus.rd = 32'h0;
            endcase
        end
    end

    assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder. Expected values are pushed onto a
// scoreboard queue when the stimulus is driven, then popped and compared
// with the DUT output.
module tb_dmem_mmio_responder;

    logic        clk;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        irq;

    dmem_mmio_responder_if bus();

    dmem_mmio_responder #(.DEPTH_WORDS(256), .MMIO_BASE(32'h0000_0800)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic expect_val(input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", t, obs, e);
        end
    endtask

    // Read: drive the address, let the combinational path settle, then compare.
    task automatic rdc(input logic [31:0] a, input logic [31:0] e, input string tag);
        expect_val(e, tag);
        bus.addr = a;
        bus.we   = 1'b0;
        #1;
        check_out(bus.rd);
    endtask

    task automatic chk_sig(input logic [31:0] obs, input logic [31:0] e, input string tag);
        expect_val(e, tag);
        check_out(obs);
    endtask

    // Write: drive the bus in the low phase and commit it on the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.wd   = d;
        bus.we   = 1'b1;
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
        bus.addr = 32'hFFFF_FFF0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        gpio_in  = 32'h0;
        bus.addr = 32'h0;
        bus.wd   = 32'h0;
        bus.we   = 1'b0;
        #1;
        // Reset state, checked before any clock edge.
        chk_sig(gpio_out, 32'h0, "rst_gpio_out");
        chk_sig({31'd0, irq}, 32'h0, "rst_irq");
        rdc(32'h808, 32'h0, "rst_ctrl");
        rdc(32'h80C, 32'h0, "rst_load");
        rdc(32'h810, 32'h0, "rst_count");
        rdc(32'h814, 32'h0, "rst_stat");
        tick(2);
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        // RAM access with byte-offset aliasing.
        wr(32'h0,  32'hDEAD_BEEF);
        wr(32'h14, 32'h1111_2222);
        wr(32'h10, 32'hCAFE_F00D);
        rdc(32'h10, 32'hCAFE_F00D, "ram_rd_10");
        rdc(32'h13, 32'hCAFE_F00D, "ram_rd_13");
        rdc(32'h14, 32'h1111_2222, "ram_rd_14");

        // GPIO output and the two-stage input synchronizer.
        wr(32'h804, 32'h0000_00A5);
        chk_sig(gpio_out, 32'hA5, "gpio_out");
        rdc(32'h804, 32'hA5, "gpio_out_rd");
        rdc(32'h800, 32'h0, "gpio_in_old");
        @(negedge clk);
        gpio_in = 32'h3C;
        tick(1);
        rdc(32'h800, 32'h0, "gpio_in_edge1");
        tick(1);
        rdc(32'h800, 32'h3C, "gpio_in_edge2");

`ifdef DMEM_TIMER_EN
        // Auto-reload timer with LOAD=3, so the period is 4 cycles.
        wr(32'h80C, 32'd3);
        rdc(32'h810, 32'd3, "count_after_load");
        wr(32'h808, 32'h7);
        rdc(32'h808, 32'h7, "ctrl_rd");
        tick(3);
        rdc(32'h810, 32'd0, "count_at_zero");
        rdc(32'h814, 32'h0, "stat_before_exp");
        chk_sig({31'd0, irq}, 32'h0, "irq_before_exp");
        tick(1);
        rdc(32'h814, 32'h1, "stat_expired");
        chk_sig({31'd0, irq}, 32'h1, "irq_set");
        rdc(32'h810, 32'd3, "count_reload");
        wr(32'h814, 32'h1);
        rdc(32'h814, 32'h0, "stat_w1c");
        rdc(32'h810, 32'd2, "count_after_clear");
        tick(2);
        rdc(32'h810, 32'd0, "count_zero_2");
        wr(32'h814, 32'h1);
        rdc(32'h814, 32'h1, "set_beats_w1c");
        rdc(32'h810, 32'd3, "count_reload_2");

        // One-shot timer with LOAD=2: it expires on the third edge.
        wr(32'h808, 32'h0);
        wr(32'h814, 32'h3);
        rdc(32'h814, 32'h0, "stat_clear_all");
        wr(32'h80C, 32'd2);
        wr(32'h808, 32'h1);
        tick(2);
        rdc(32'h814, 32'h0, "oneshot_not_yet");
        rdc(32'h808, 32'h1, "oneshot_en");
        tick(1);
        rdc(32'h814, 32'h1, "oneshot_expired");
        rdc(32'h808, 32'h0, "oneshot_ctrl_cleared");
        rdc(32'h810, 32'h0, "oneshot_count");
        chk_sig({31'd0, irq}, 32'h0, "oneshot_irq_ie0");
        tick(2);
        rdc(32'h810, 32'h0, "oneshot_count_hold");
        wr(32'h814, 32'h1);
        wr(32'h810, 32'h55);
        rdc(32'h810, 32'h0, "count_ro");
`else
        // Without the timer, its offsets ignore writes and read 0.
        wr(32'h80C, 32'd3);
        wr(32'h808, 32'h7);
        tick(3);
        rdc(32'h808, 32'h0, "notmr_ctrl");
        rdc(32'h80C, 32'h0, "notmr_load");
        rdc(32'h810, 32'h0, "notmr_count");
        rdc(32'h814, 32'h0, "notmr_stat");
        chk_sig({31'd0, irq}, 32'h0, "notmr_irq");
`endif

        // Unmapped write: bus_err is set and the write is discarded.
        wr(32'h4000, 32'h1234_5678);
        rdc(32'h814, 32'h2, "bus_err_set");
        rdc(32'h4000, 32'h0, "unmapped_rd");
        rdc(32'h0, 32'hDEAD_BEEF, "ram0_untouched");
        rdc(32'h10, 32'hCAFE_F00D, "ram10_untouched");
        chk_sig(gpio_out, 32'hA5, "gpio_untouched");
        rdc(32'h4000, 32'h0, "unmapped_rd_again");
        tick(1);
        rdc(32'h814, 32'h2, "bus_err_no_rd_set");
        wr(32'h814, 32'h2);
        rdc(32'h814, 32'h0, "bus_err_w1c");

`ifdef DMEM_TIMER_EN
        // Raise irq with LOAD=0, auto=0 and ie=1 before the reset test.
        wr(32'h80C, 32'd0);
        wr(32'h808, 32'h5);
        tick(1);
        chk_sig({31'd0, irq}, 32'h1, "irq_pre_reset");
`endif
        // Assert reset in mid-cycle. Its effect must appear without a clock edge.
        #3;
        rst = 1'b1;
        #1;
        chk_sig(gpio_out, 32'h0, "async_rst_gpio");
        chk_sig({31'd0, irq}, 32'h0, "async_rst_irq");
        rdc(32'h808, 32'h0, "async_rst_ctrl");
        rdc(32'h814, 32'h0, "async_rst_stat");
        rdc(32'h10, 32'hCAFE_F00D, "ram_survives_rst");
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Data-side memory responder for the pipelined MIPS core: the slave end of the core's data-memory port (address, write data, write enable in; read data out).
- Decodes each access to word RAM, a small MMIO register block (GPIO plus a down-counting timer), or unmapped space.
- Answers reads combinationally in the same cycle; commits writes on the clock edge.
- Sits at top level between the core and the board I/O.

Parameters:
DEPTH_WORDS, 256, data RAM size in 32-bit words; power of 2, ≥16; RAM occupies byte addresses 0 .. DEPTH_WORDS*4-1
MMIO_BASE, 32'h0000_0800, byte base of the MMIO block (8 words); must lie above the RAM range, 32-byte aligned

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
addr  input  32  byte address from the core's M stage (ALU result)
wd  input  32  store data
we  input  1  store enable, sampled on rising clk
rd  output  32  load data, combinational from addr and current state
gpio_in  input  32  board inputs, asynchronous
gpio_out  output  32  board outputs, registered
irq  output  1  timer interrupt level: TMR_STAT.expired & TMR_CTRL.ie

Behaviour:
- Reset: clk single clock; rst asynchronous active-high.
  - Reset values: gpio_out=0, CTRL=0, LOAD=0, COUNT=0, STAT=0, synchronizer flops=0, irq=0.
  - RAM contents are not reset.
  - rd is combinational, so it reflects decode of addr with reset register values.
- Addressing: addr[1:0] ignored (word access only).
  - RAM hit: addr < DEPTH_WORDS*4; index = addr[log2(DEPTH_WORDS)+1:2].
  - MMIO hit: addr[31:5] == MMIO_BASE[31:5]; offset = addr[4:2].
  - Anything else: unmapped.
- Read: zero-latency; rd = RAM word, MMIO register, or 32'h0 when unmapped.
- Write: when we=1 at a rising edge, the target updates at that edge; a read of the same address in the next cycle returns the new value.
- MMIO map (offsets):
  - 0x00 GPIO_IN, RO: 2-flop synchronized gpio_in; a level change appears in reads 2 edges later.
  - 0x04 GPIO_OUT, RW: drives gpio_out.
  - 0x08 TMR_CTRL, RW: bit0 en, bit1 auto, bit2 ie; other bits read 0.
  - 0x0C TMR_LOAD, RW: a write also sets COUNT <= wd at the same edge.
  - 0x10 TMR_COUNT, RO: writes ignored.
  - 0x14 TMR_STAT, W1C: bit0 expired, bit1 bus_err.
  - 0x18, 0x1C: read 0, writes ignored.
- Bus error: any write (we=1) to unmapped space sets STAT.bus_err; the write is discarded. Unmapped reads do not set bus_err.
- Timer FSM: states IDLE (en=0) and RUN (en=1). In RUN, each edge:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: set STAT.expired. If auto=1, COUNT <= LOAD and stay in RUN. If auto=0, clear en and go to IDLE.
  - Period with auto = LOAD+1 cycles. Enabling with COUNT=0 expires on the first edge.
- Simultaneous events:
  - Hardware set of expired or bus_err beats a W1C clear in the same cycle.
  - A LOAD write beats the decrement/reload of COUNT.
  - A software CTRL write beats the hardware en clear at one-shot expiry.
- Reset mid-count: the timer returns to IDLE immediately (asynchronous); irq drops without waiting for a clock edge.

Optional Feature:
DMEM_TIMER_EN
- Defined: timer registers, FSM and irq are implemented as above.
- Undefined: no timer logic. Offsets 0x08–0x10 read 0 and ignore writes; STAT.expired reads 0; irq tied 0. GPIO, RAM and bus_err are unchanged.

Test Plan:
1. Assert rst mid-cycle -> gpio_out=0 and irq=0 immediately, before any clock edge; reads of 0x808–0x814 = 0.
2. RAM: write 0xCAFEF00D to 0x10, then read 0x10 and 0x13 -> rd=0xCAFEF00D next cycle for both; read 0x14 unaffected.
3. GPIO: write 0xA5 to 0x804 -> gpio_out=0xA5 after the edge. Drive gpio_in=0x3C -> read 0x800 returns 0x3C from the 2nd edge onward, previous value before that.
4. Timer auto:
   - Setup: LOAD=3, then CTRL=0b111.
   - Expected: expired sets on the 4th edge after enable; irq=1; COUNT reloads to 3; expired sets again 4 cycles later.
   - Write 1 to 0x814 in the same cycle as an expiry -> expired stays 1.
5. One-shot: LOAD=2, CTRL=0b001 -> expired after 3 edges; CTRL reads 0; COUNT holds 0.
6. Unmapped: write to 0x4000 -> STAT reads 0x2 and no RAM/MMIO state changes; read 0x4000 -> rd=0. Write 0x2 to 0x814 -> STAT=0.
